updown_counter_7seg: RTL and testbench
======================================

// Module: updown_counter_7seg
// PURPOSE
// - 4-bit loadable up/down counter, stepped by an internal 1 Hz-class tick, shown on one 7-segment digit.
// - Three sub-blocks: cntdiv_n (tick generator), counter (4-bit state), deco7seg_hexa (hex to segment decoder).
// - Board-level top for a single digit; segment outputs are active-low.
// PARAMETERS
// - FPGAFREQ  50_000_000  Clock cycles per counter tick. Legal range is FPGAFREQ >= 1.
// PORTS
// - CLK   in   1  Single system clock; all logic runs on its rising edge.
// - RST   in   1  Synchronous, active-low reset.
// - EN    in   1  Count enable; a step happens only when EN=1.
// - S     in   2  Mode select: 00 hold, 01 load D, 10 count up, 11 count down.
// - D     in   4  Parallel load value.
// - SEG   out  8  Active-low segments. SEG[7]=dp; SEG[6:0]=g,f,e,d,c,b,a.
// BEHAVIOUR
// - Reset (RST=0 at a clock edge):
//   - Divider count goes to 0. Q goes to 0. Optional dp state goes to 0.
//   - SEG = 8'hC0 from the next edge onward; RST has priority over every other input.
// - Divider (cntdiv_n):
//   - cnt counts 0 .. FPGAFREQ-1, then wraps to 0; cnt width is $clog2(FPGAFREQ), minimum 1.
//   - tick is a one-CLK pulse, asserted while cnt == FPGAFREQ-1.
//   - cnt is free-running and independent of EN and S.
//   - FPGAFREQ=1 gives tick=1 on every cycle.
//   - tick is used as an enable; it is never used as a clock (single clock domain).
// - Counter (counter), updated on an edge where tick=1 and EN=1:
//   - S=00: Q holds.
//   - S=01: Q <= D.
//   - S=10: Q <= Q+1; F wraps to 0.
//   - S=11: Q <= Q-1; 0 wraps to F.
//   - If tick=0 or EN=0, Q holds.
//   - S, EN and D are sampled only on the tick edge; changes between ticks have no effect.
// - Decoder (deco7seg_hexa):
//   - Purely combinational from Q; the segment pattern appears in the same cycle Q changes.
//   - Uppercase/lowercase forms: 0-9, A, b, C, d, E, F.
//   - Active-low SEG values for Q = 0..F:
//     - 0..7: C0 F9 A4 B0 99 92 82 F8
//     - 8..F: 80 90 88 83 C6 A1 86 8E
//   - The decoder is built active-high and inverted at the output.
// - Latency: Q and SEG update 1 CLK after the tick cycle, i.e. every FPGAFREQ clocks while enabled.
// - Reset mid-operation: the divider restarts, so the first tick after release comes FPGAFREQ cycles later.
// CONFIGURATION
// - Macro SEG_DP_HEARTBEAT_EN.
//   - Defined: a 1-bit dp state toggles on every tick, independent of EN. SEG[7] = ~dp_state, so the dp blinks at half the tick rate.
//   - Undefined: SEG[7] = 1 permanently (dp off); no dp state register exists.
//   - SEG[6:0] behaviour is identical in both builds.
// TESTING
// All scenarios use FPGAFREQ=4 and a 20 ns CLK.
// - Reset: RST=0 for 4 clocks -> SEG=8'hC0, Q=0. Release -> first change exactly 4 clocks later.
// - Count up (S=10, EN=1): SEG steps C0,F9,A4,... every 4 clocks; after F (8E) it wraps to 0 (C0).
// - Count down (S=11) from Q=0 -> next tick SEG=8'h8E (F), then 86 (E), and so on.
// - Load (S=01, D=4'hA) -> next tick SEG=8'h88. Changing D between ticks has no effect until the following tick.
// - Hold: EN=0 or S=00 for 5 ticks -> SEG constant. Re-enabling resumes from the held value.
// - Reset mid-count: RST=0 at Q=7 for 1 edge -> SEG=C0 next edge. With SEG_DP_HEARTBEAT_EN, SEG[7] toggles every 4 clocks; without it, SEG[7]=1 always.

Source files
------------

// File: rtl/updown_counter_7seg.sv
// updown_counter_7seg: 4-bit loadable up/down counter shown on one
// active-low 7-segment digit.
//
// Sub-blocks:
//   cntdiv_n      - free-running divider that produces a one-cycle tick
//   counter       - 4-bit state, stepped only on tick while EN=1
//   deco7seg_hexa - hex to segment decoder (active-high, inverted at top)
//
// Optional build macro: SEG_DP_HEARTBEAT_EN
//   defined   -> the decimal point toggles on every tick (heartbeat)
//   undefined -> the decimal point is permanently off (SEG[7]=1)
//
// Everything runs on the rising edge of CLK. RST is synchronous and
// active-low, and it overrides every other input.

// ---------------------------------------------------------------------------
// cntdiv_n: counts 0..FPGAFREQ-1 and asserts tick during the last count.
// ---------------------------------------------------------------------------
module cntdiv_n #(
  parameter int unsigned FPGAFREQ = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  // A divide-by-one still needs a one-bit counter so that the ports stay legal.
  localparam int unsigned CW = (FPGAFREQ > 1) ? $clog2(FPGAFREQ) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FPGAFREQ - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          wrap_s;

  // The terminal count doubles as the tick; it is an enable, never a clock.
  assign wrap_s = (cnt_q == CNT_LAST);
  assign tick   = wrap_s;

  // Next divider count: wrap to zero after the terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (wrap_s) begin
      cnt_d = CNT_ZERO;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Divider register; the synchronous reset restarts the tick phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// ---------------------------------------------------------------------------
// counter: 4-bit hold / load / up / down register stepped by tick & en.
// ---------------------------------------------------------------------------
module counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       en,
  input  logic [1:0] s,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] q_q;
  logic [3:0] q_d;
  logic [3:0] step_s;

  // Mode decode; the 4-bit arithmetic wraps naturally F->0 and 0->F.
  always_comb begin
    step_s = q_q;
    case (s)
      2'b00:   step_s = q_q;
      2'b01:   step_s = d;
      2'b10:   step_s = q_q + 4'd1;
      2'b11:   step_s = q_q - 4'd1;
      default: step_s = q_q;
    endcase
  end

  // Inputs only matter on the tick edge; otherwise the state holds.
  always_comb begin
    q_d = q_q;
    if (tick && en) begin
      q_d = step_s;
    end else begin
      q_d = q_q;
    end
  end

  // Counter state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// ---------------------------------------------------------------------------
// deco7seg_hexa: hex digit to segments {g,f,e,d,c,b,a}.
// The table is written active-high (1 = lit); the output is active-low.
// ---------------------------------------------------------------------------
module deco7seg_hexa (
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);

  logic [6:0] seg_ah_s;

  // Active-high glyph table: 0-9, A, b, C, d, E, F.
  always_comb begin
    seg_ah_s = 7'h00;
    case (hex)
      4'h0:    seg_ah_s = 7'h3F;
      4'h1:    seg_ah_s = 7'h06;
      4'h2:    seg_ah_s = 7'h5B;
      4'h3:    seg_ah_s = 7'h4F;
      4'h4:    seg_ah_s = 7'h66;
      4'h5:    seg_ah_s = 7'h6D;
      4'h6:    seg_ah_s = 7'h7D;
      4'h7:    seg_ah_s = 7'h07;
      4'h8:    seg_ah_s = 7'h7F;
      4'h9:    seg_ah_s = 7'h6F;
      4'hA:    seg_ah_s = 7'h77;
      4'hB:    seg_ah_s = 7'h7C;
      4'hC:    seg_ah_s = 7'h39;
      4'hD:    seg_ah_s = 7'h5E;
      4'hE:    seg_ah_s = 7'h79;
      4'hF:    seg_ah_s = 7'h71;
      default: seg_ah_s = 7'h00;
    endcase
  end

  // The board drives segments low to light them.
  assign seg_n = ~seg_ah_s;

endmodule

// ---------------------------------------------------------------------------
// updown_counter_7seg: board-level top for one digit.
// ---------------------------------------------------------------------------
module updown_counter_7seg #(
  parameter int unsigned FPGAFREQ = 50_000_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic [1:0] S,
  input  logic [3:0] D,
  output logic [7:0] SEG
);

  logic       tick_s;
  logic [3:0] q_s;
  logic [6:0] seg_n_s;
  logic       dp_n_s;

  cntdiv_n #(
    .FPGAFREQ (FPGAFREQ)
  ) u_cntdiv (
    .clk   (CLK),
    .rst_n (RST),
    .tick  (tick_s)
  );

  counter u_counter (
    .clk   (CLK),
    .rst_n (RST),
    .tick  (tick_s),
    .en    (EN),
    .s     (S),
    .d     (D),
    .q     (q_s)
  );

  deco7seg_hexa u_deco (
    .hex   (q_s),
    .seg_n (seg_n_s)
  );

`ifdef SEG_DP_HEARTBEAT_EN
  logic dp_q;
  logic dp_d;

  // Heartbeat: the dp flips on every tick, whether or not counting is enabled.
  always_comb begin
    dp_d = dp_q;
    if (tick_s) begin
      dp_d = ~dp_q;
    end else begin
      dp_d = dp_q;
    end
  end

  // Heartbeat register; it comes out of reset with the dp dark.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      dp_q <= 1'b0;
    end else begin
      dp_q <= dp_d;
    end
  end

  assign dp_n_s = ~dp_q;
`else
  // Without the heartbeat the decimal point stays dark.
  assign dp_n_s = 1'b1;
`endif

  // Segments follow Q in the same cycle because the decoder is combinational.
  assign SEG = {dp_n_s, seg_n_s};

endmodule

// File: tb/tb_updown_counter_7seg.sv
// Testbench for updown_counter_7seg with FPGAFREQ=4 and a 20 ns clock.
// Stimulus pushes expected SEG values, each tagged with the clock cycle at
// which it must be visible, into a queue. A separate monitor samples SEG on
// every falling edge and pops and compares each entry that has come due.
module tb_updown_counter_7seg;

  localparam int unsigned FREQ = 4;

`ifdef SEG_DP_HEARTBEAT_EN
  localparam bit DP_ON = 1'b1;
`else
  localparam bit DP_ON = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] s;
  logic [3:0] d;
  logic [7:0] seg;

  typedef struct {
    int         cyc;
    logic [7:0] seg;
    string      name;
  } exp_t;

  exp_t       sb_q[$];
  int         cyc;
  int         tests;
  int         fails;
  logic [7:0] prev_seg;
  logic       dp_exp;
  logic       done;

  // Hand-computed SEG codes for counting up from 0: values 1..F, then a wrap to 0.
  logic [7:0] up_tab [0:15] = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80,
                                8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E, 8'hC0};

  updown_counter_7seg #(
    .FPGAFREQ (FREQ)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .EN  (en),
    .S   (s),
    .D   (d),
    .SEG (seg)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected dp bit: dark (1) if the heartbeat is absent, otherwise ~dp state.
  function automatic logic [7:0] with_dp(input logic [7:0] v, input logic dp);
    return {(DP_ON ? ~dp : 1'b1), v[6:0]};
  endfunction

  task automatic push(input int c, input logic [7:0] v, input string nm);
    exp_t e;
    e.cyc  = c;
    e.seg  = v;
    e.name = nm;
    sb_q.push_back(e);
  endtask

  // One tick period. Entered 1 ns after a tick edge (or after the edge that
  // releases reset). The inputs glitch between ticks; that must not matter.
  task automatic do_step(input logic en_i, input logic [1:0] s_i, input logic [3:0] d_i,
                         input logic [7:0] seg_i, input string nm);
    int   c0;
    logic dp_new;
    c0     = cyc;
    dp_new = ~dp_exp;
    en = en_i; s = s_i; d = d_i;
    for (int k = 1; k < 4; k++)
      push(c0 + k, prev_seg, $sformatf("%s_hold%0d", nm, k));
    push(c0 + 4, with_dp(seg_i, dp_new), nm);
    @(posedge clk); #1;
    en = ~en_i; s = ~s_i; d = ~d_i;
    @(posedge clk); #1;
    en = en_i; s = s_i; d = d_i;
    @(posedge clk);
    @(posedge clk); #1;
    dp_exp   = dp_new;
    prev_seg = with_dp(seg_i, dp_new);
  endtask

  // Scoreboard monitor: compare every entry that is due in this cycle.
  initial begin
    tests = 0;
    fails = 0;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        exp_t e;
        e = sb_q.pop_front();
        tests++;
        if (e.cyc < cyc) begin
          fails++;
          $display("FAIL %s: checked late at cycle %0d (due %0d), seg=%h required=%h",
                   e.name, cyc, e.cyc, seg, e.seg);
        end else if (seg !== e.seg) begin
          fails++;
          $display("FAIL %s: cycle %0d seg=%h required=%h", e.name, cyc, seg, e.seg);
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    done = 1'b0;
    rst = 1'b0; en = 1'b0; s = 2'b00; d = 4'h0;
    dp_exp = 1'b0;
    for (int k = 1; k <= 4; k++)
      push(k, 8'hC0, $sformatf("reset%0d", k));
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    prev_seg = 8'hC0;

    // Count up through F and wrap back to 0.
    for (int i = 0; i < 16; i++)
      do_step(1'b1, 2'b10, 4'h0, up_tab[i], $sformatf("up%0d", i));

    // Count down from 0: F, E, d.
    do_step(1'b1, 2'b11, 4'h0, 8'h8E, "down_F");
    do_step(1'b1, 2'b11, 4'h0, 8'h86, "down_E");
    do_step(1'b1, 2'b11, 4'h0, 8'hA1, "down_d");

    // Load A.
    do_step(1'b1, 2'b01, 4'hA, 8'h88, "load_A");

    // Hold with EN=0 (S=up, D=3 to show they are ignored), then with S=00.
    for (int i = 0; i < 5; i++)
      do_step(1'b0, 2'b10, 4'h3, 8'h88, $sformatf("hold_en%0d", i));
    for (int i = 0; i < 5; i++)
      do_step(1'b1, 2'b00, 4'h3, 8'h88, $sformatf("hold_s%0d", i));

    // Resume from the held value.
    do_step(1'b1, 2'b10, 4'h0, 8'h83, "resume_b");
    do_step(1'b1, 2'b11, 4'h0, 8'h88, "resume_A");

    // Load 6, step up to 7, then reset for a single edge.
    do_step(1'b1, 2'b01, 4'h6, 8'h82, "load_6");
    do_step(1'b1, 2'b10, 4'h0, 8'hF8, "up_7");
    rst = 1'b0;
    push(cyc + 1, 8'hC0, "midreset");
    @(posedge clk); #1;
    rst = 1'b1;
    dp_exp   = 1'b0;
    prev_seg = 8'hC0;
    do_step(1'b1, 2'b10, 4'h0, 8'hF9, "after_reset");
    done = 1'b1;
  end

  // Finish once the queue drains; a stuck queue or run-away stimulus is a failure.
  initial begin
    int budget;
    budget = 0;
    while (!(done && sb_q.size() == 0) && budget < 2000) begin
      @(posedge clk);
      budget++;
    end
    @(negedge clk);
    if (sb_q.size() != 0 || !done) begin
      tests++;
      fails++;
      $display("FAIL timeout: %0d entries pending, stimulus done=%0d, required 0 pending",
               sb_q.size(), done);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
